// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream receive channel and program RAM write port
interface program_loader_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic mem_we;
  logic [7:0] mem_addr;
  logic [15:0] mem_data;
  modport master (input rx_data, rx_valid, output rx_ready, mem_we, mem_addr, mem_data);
  modport slave (output rx_data, rx_valid, input rx_ready, mem_we, mem_addr, mem_data);
endinterface

// File: rtl/program_loader.sv
// program_loader: loads count-prefixed 16-bit words into CPU program RAM; LOADER_CHECKSUM_EN adds a trailing checksum byte
module program_loader (
  input logic clk,
  input logic clr,
  input logic start,
  program_loader_if.master bus,
  output logic cpu_nclr,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [2:0] {
    IDLE, COUNT, HI, LO, WRITE, DONE
`ifdef LOADER_CHECKSUM_EN
    , CHK, FAIL
`endif
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, nxt;
  logic [7:0] addr, cnt;
  logic [15:0] data;
  logic acc, go, chk_st, fail_st;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  assign chk_st = state == CHK;
  assign fail_st = state == FAIL;
`else
  assign chk_st = 1'b0;
  assign fail_st = 1'b0;
`endif
  assign bus.rx_ready = state == COUNT || state == HI || state == LO || chk_st;
  assign bus.mem_we = state == WRITE;
  assign bus.mem_addr = addr;
  assign bus.mem_data = data;
  assign busy = bus.rx_ready || state == WRITE;
  assign done = state == DONE;
  assign err = fail_st;
  assign cpu_nclr = done;
  assign acc = bus.rx_valid && bus.rx_ready;
  assign go = start && (state == IDLE || state == DONE || fail_st);
  always_comb begin
    nxt = state;
    case (state)
      COUNT: nxt = acc ? (bus.rx_data == 8'd0 ? FIN : HI) : COUNT;
      HI: nxt = acc ? LO : HI;
      LO: nxt = acc ? WRITE : LO;
      WRITE: nxt = cnt == 8'd1 ? FIN : HI;
`ifdef LOADER_CHECKSUM_EN
      CHK: nxt = acc ? (bus.rx_data == sum ? DONE : FAIL) : CHK;
`endif
      default: nxt = go ? COUNT : state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      addr <= 8'h00;
      cnt <= 8'h00;
      data <= 16'h0000;
    end else begin
      state <= nxt;
      if (go) addr <= 8'h00;
      if (acc && state == COUNT) cnt <= bus.rx_data;
      if (acc && state == HI) data[15:8] <= bus.rx_data;
      if (acc && state == LO) data[7:0] <= bus.rx_data;
      if (state == WRITE) begin
        addr <= addr + 8'd1;
        cnt <= cnt - 8'd1;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  // only data bytes are summed; count and checksum bytes are excluded
  always_ff @(posedge clk) begin
    if (clr || go) sum <= 8'h00;
    else if (acc && (state == HI || state == LO)) sum <= sum + bus.rx_data;
  end
`endif
endmodule
